processor_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, for the processor front end. Keeps the instruction pointer and issues reads to synchronous code memory (one-cycle read latency). Buffers returned words with their `ip`/`ip+1` in a DEPTH-entry FIFO, which it presents to the decode stage over a valid/ready handshake. Redirects from branch and call resolution flush the queue and kill any in-flight read.

---
 rtl/processor_fetch_queue.sv | 130 +++++++++++++
 tb/tb_processor_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/processor_fetch_queue.sv
// Instruction fetch stage: keeps the IP, issues one-cycle-latency code reads and
// buffers returned words in a DEPTH-entry queue for decode. Optional FETCH_PERF_EN adds flush_count.
module processor_fetch_queue #(
  parameter int unsigned          ADDR_SIZE = 18,
  parameter int unsigned          WORD_SIZE = 18,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_IP  = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      halt,
  input  logic                      redirect,
  input  logic [ADDR_SIZE-1:0]      redirect_ip,
  output logic [ADDR_SIZE-1:0]      code_addr,
  output logic                      code_rd,
  input  logic [WORD_SIZE-1:0]      code_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_SIZE-1:0]      out_ip,
  output logic [ADDR_SIZE-1:0]      out_ip_plus_one,
  output logic [WORD_SIZE-1:0]      out_instr,
  output logic [$clog2(DEPTH):0]    queue_level
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]               flush_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned INF_W = LVL_W + 1;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] ip;
    logic [WORD_SIZE-1:0] instr;
  } entry_t;

  logic [ADDR_SIZE-1:0] r_ip;
  logic                 r_pend_v;
  logic [ADDR_SIZE-1:0] r_pend_ip;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  entry_t               r_mem [DEPTH];

  logic [ADDR_SIZE-1:0] w_addr;
  logic [INF_W-1:0]     w_inflight;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_valid;
  entry_t               w_head;

  // Read credit counts both queued entries and the read still in flight
  assign w_inflight = {1'b0, r_level} + INF_W'(r_pend_v);
  assign w_addr     = !reset ? RESET_IP : (redirect ? redirect_ip : r_ip);
  assign w_issue    = reset && !halt && (redirect || (w_inflight < INF_W'(DEPTH)));
  assign w_valid    = reset && (r_level != '0);
  assign w_push     = r_pend_v && !redirect;
  assign w_pop      = w_valid && out_ready;
  assign w_head     = r_mem[r_rd_ptr];

  assign code_addr       = w_addr;
  assign code_rd         = w_issue;
  assign out_valid       = w_valid;
  assign out_ip          = w_valid ? w_head.ip : '0;
  assign out_ip_plus_one = w_valid ? w_head.ip + ADDR_SIZE'(1) : '0;
  assign out_instr       = w_valid ? w_head.instr : '0;
  assign queue_level     = r_level;

  // Fetch pointer, pending stage and queue bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ip      <= RESET_IP;
      r_pend_v  <= 1'b0;
      r_pend_ip <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
    end else begin
      if (w_issue) begin
        r_pend_v  <= 1'b1;
        r_pend_ip <= w_addr;
        r_ip      <= w_addr + ADDR_SIZE'(1);
      end else begin
        r_pend_v <= 1'b0;
        if (redirect) r_ip <= redirect_ip;
      end
      if (redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= '{ip: r_pend_ip, instr: code_data};
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_flush;
  logic [16:0] w_flush_sum;

  // Discarded work per redirect, saturating
  assign w_flush_sum = {1'b0, r_flush} + 17'(r_level) + 17'(r_pend_v);
  assign flush_count = r_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flush <= '0;
    end else if (redirect) begin
      r_flush <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_processor_fetch_queue.sv
// Directed table-driven bench for processor_fetch_queue, plus reset-restart and IP-wrap sequences.
module tb_processor_fetch_queue;

  localparam int unsigned AW = 18;
  localparam int unsigned WW = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic          halt, redirect, out_ready;
  logic [AW-1:0] redirect_ip;
  logic [AW-1:0] code_addr, out_ip, out_ip_plus_one;
  logic          code_rd, out_valid;
  logic [WW-1:0] code_data, out_instr;
  logic [2:0]    queue_level;

  logic [AW-1:0] code_addr2, out_ip2, out_ip_plus_one2;
  logic          code_rd2, out_valid2;
  logic [WW-1:0] code_data2, out_instr2;
  logic [2:0]    queue_level2;
  logic          halt2 = 1'b0, redirect2 = 1'b0, ready2 = 1'b1;
  logic [AW-1:0] rip2 = '0;

`ifdef FETCH_PERF_EN
  logic [15:0]   flush_count, flush_count2;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic ovf_seen = 1'b0;
  logic pend_b;

  always #5 clock = ~clock;

  processor_fetch_queue dut (
    .clock(clock), .reset(reset), .halt(halt), .redirect(redirect),
    .redirect_ip(redirect_ip), .code_addr(code_addr), .code_rd(code_rd),
    .code_data(code_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ip(out_ip), .out_ip_plus_one(out_ip_plus_one), .out_instr(out_instr),
    .queue_level(queue_level)
`ifdef FETCH_PERF_EN
    , .flush_count(flush_count)
`endif
  );

  processor_fetch_queue #(.RESET_IP(18'h3FFFF)) dut2 (
    .clock(clock), .reset(reset), .halt(halt2), .redirect(redirect2),
    .redirect_ip(rip2), .code_addr(code_addr2), .code_rd(code_rd2),
    .code_data(code_data2), .out_valid(out_valid2), .out_ready(ready2),
    .out_ip(out_ip2), .out_ip_plus_one(out_ip_plus_one2), .out_instr(out_instr2),
    .queue_level(queue_level2)
`ifdef FETCH_PERF_EN
    , .flush_count(flush_count2)
`endif
  );

  function automatic logic [WW-1:0] ins(input logic [AW-1:0] a);
    return WW'(a ^ 18'h2A5A5);
  endfunction

  // Synchronous code memories, one-cycle latency
  always @(posedge clock) begin
    if (code_rd)  code_data  <= ins(code_addr);
    if (code_rd2) code_data2 <= ins(code_addr2);
  end

  // Flags any push into a full queue without a simultaneous pop
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_b <= 1'b0;
    end else begin
      if (pend_b && !redirect && queue_level == 3'd4 && !(out_valid && out_ready))
        ovf_seen <= 1'b1;
      pend_b <= code_rd;
    end
  end

  typedef struct {
    logic          halt;
    logic          redir;
    logic [AW-1:0] rip;
    logic          rdy;
    logic          e_rd;
    logic [AW-1:0] e_addr;
    logic          e_valid;
    logic [AW-1:0] e_ip;
    logic [2:0]    e_lvl;
    int            e_flush;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic h, input logic r, input logic [AW-1:0] rip,
                              input logic rdy, input logic erd, input logic [AW-1:0] eaddr,
                              input logic ev, input logic [AW-1:0] eip, input logic [2:0] elvl,
                              input int efl);
    vec_t v;
    v.halt = h; v.redir = r; v.rip = rip; v.rdy = rdy;
    v.e_rd = erd; v.e_addr = eaddr; v.e_valid = ev; v.e_ip = eip; v.e_lvl = elvl;
    v.e_flush = efl;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [AW-1:0] eip);
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".ip"}, 32'(out_ip), 32'(ev ? eip : '0));
    chk({tag, ".ip1"}, 32'(out_ip_plus_one), 32'(ev ? AW'(eip + AW'(1)) : '0));
    chk({tag, ".instr"}, 32'(out_instr), 32'(ev ? ins(eip) : '0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stream, stall to full, drain, redirect with 3 queued + 1 in flight, halt, redirect while halted
    add(0,0,'0,1, 1,18'h000, 0,'0,0, -1);
    add(0,0,'0,1, 1,18'h001, 0,'0,0, -1);
    add(0,0,'0,1, 1,18'h002, 1,18'h000,1, -1);
    add(0,0,'0,1, 1,18'h003, 1,18'h001,1, -1);
    add(0,0,'0,1, 1,18'h004, 1,18'h002,1, -1);
    add(0,0,'0,0, 1,18'h005, 1,18'h003,1, -1);
    add(0,0,'0,0, 1,18'h006, 1,18'h003,2, -1);
    add(0,0,'0,0, 0,18'h007, 1,18'h003,3, -1);
    for (int k = 0; k < 7; k++) add(0,0,'0,0, 0,18'h007, 1,18'h003,4, -1);
    add(0,0,'0,1, 0,18'h007, 1,18'h003,4, -1);
    add(0,0,'0,1, 1,18'h007, 1,18'h004,3, -1);
    add(0,0,'0,1, 1,18'h008, 1,18'h005,2, -1);
    add(0,0,'0,1, 1,18'h009, 1,18'h006,2, -1);
    add(0,0,'0,1, 1,18'h00A, 1,18'h007,2, -1);
    add(0,0,'0,0, 1,18'h00B, 1,18'h008,2, -1);
    add(0,1,18'h100,0, 1,18'h100, 1,18'h008,3, 0);
    add(0,0,'0,1, 1,18'h101, 0,'0,0, 4);
    add(0,0,'0,1, 1,18'h102, 1,18'h100,1, -1);
    add(0,0,'0,1, 1,18'h103, 1,18'h101,1, -1);
    add(1,0,'0,1, 0,18'h104, 1,18'h102,1, -1);
    add(1,0,'0,1, 0,18'h104, 1,18'h103,1, -1);
    add(0,0,'0,1, 1,18'h104, 0,'0,0, -1);
    add(0,0,'0,1, 1,18'h105, 0,'0,0, -1);
    add(0,0,'0,1, 1,18'h106, 1,18'h104,1, -1);
    add(1,1,18'h200,1, 0,18'h200, 1,18'h105,1, 4);
    add(0,0,'0,1, 1,18'h200, 0,'0,0, 6);
    add(0,0,'0,1, 1,18'h201, 0,'0,0, -1);
    add(0,0,'0,1, 1,18'h202, 1,18'h200,1, -1);

    // Reset held with a redirect request present
    reset = 1'b0; halt = 1'b0; redirect = 1'b1; redirect_ip = 18'h055; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst.rd", 32'(code_rd), 32'd0);
    chk("rst.addr", 32'(code_addr), 32'd0);
    chk("rst.lvl", 32'(queue_level), 32'd0);
    chk_out("rst", 1'b0, '0);
    chk("rst2.addr", 32'(code_addr2), 32'h3FFFF);
`ifdef FETCH_PERF_EN
    chk("rst.flush", 32'(flush_count), 32'd0);
`endif

    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      halt = vq[i].halt; redirect = vq[i].redir; redirect_ip = vq[i].rip; out_ready = vq[i].rdy;
      #1;
      chk({t, ".rd"}, 32'(code_rd), 32'(vq[i].e_rd));
      chk({t, ".addr"}, 32'(code_addr), 32'(vq[i].e_addr));
      chk({t, ".lvl"}, 32'(queue_level), 32'(vq[i].e_lvl));
      chk_out(t, vq[i].e_valid, vq[i].e_ip);
`ifdef FETCH_PERF_EN
      if (vq[i].e_flush >= 0) chk({t, ".flush"}, 32'(flush_count), 32'(vq[i].e_flush));
`endif
      @(negedge clock);
    end

    // Reset mid-stream: outputs drop at once, fetch restarts from RESET_IP
    halt = 1'b0; redirect = 1'b0; redirect_ip = '0; out_ready = 1'b1;
    #1;
    chk("pre.valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid.rd", 32'(code_rd), 32'd0);
    chk("mid.addr", 32'(code_addr), 32'd0);
    chk("mid.lvl", 32'(queue_level), 32'd0);
    chk_out("mid", 1'b0, '0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("re0.rd", 32'(code_rd), 32'd1);
    chk("re0.addr", 32'(code_addr), 32'd0);
    chk("re0.valid", 32'(out_valid), 32'd0);
    chk("w0.addr", 32'(code_addr2), 32'h3FFFF);
`ifdef FETCH_PERF_EN
    chk("re0.flush", 32'(flush_count), 32'd0);
`endif
    @(negedge clock); #1;
    chk("re1.addr", 32'(code_addr), 32'd1);
    chk("w1.addr", 32'(code_addr2), 32'd0);
    @(negedge clock); #1;
    chk_out("re2", 1'b1, 18'h000);
    chk("w2.valid", 32'(out_valid2), 32'd1);
    chk("w2.ip", 32'(out_ip2), 32'h3FFFF);
    chk("w2.ip1", 32'(out_ip_plus_one2), 32'd0);
    chk("w2.instr", 32'(out_instr2), 32'(ins(18'h3FFFF)));
    @(negedge clock); #1;
    chk_out("re3", 1'b1, 18'h001);
    chk("w3.ip", 32'(out_ip2), 32'd0);
    chk("w3.ip1", 32'(out_ip_plus_one2), 32'd1);

    chk("no_overflow", 32'(ovf_seen), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
